ps2_key_event_fifo: RTL and testbench
=====================================

Name: ps2_key_event_fifo

Overview:
- Parametrised successor to the team's keyboard letter decoder.
- Receives raw PS/2 frames, checks parity and framing, and tracks make/break/extended prefixes with an FSM.
- Maps scancodes to the 5-bit letter index and buffers press/release events in a FIFO with valid/ready handshake.
- Sits between the keyboard pins and game logic; the consumer no longer has to sample a level that changes per byte.

Parameters:
- FIFO_DEPTH, 8: event FIFO entries; power of 2, minimum 2.
- REPORT_RELEASE, 1: 1 = push release events; 0 = push make events only.
- TIMEOUT_CYCLES, 100000: clk cycles without a kbdclk falling edge before a partial frame is discarded.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- kbdclk  in  1  raw PS/2 clock, asynchronous to clk
- kbddat  in  1  raw PS/2 data, asynchronous to clk
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts head when evt_valid & evt_ready
- evt_letter  out  5  letter index of head event (1..18)
- evt_release  out  1  head event is a key release
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- frame_err  out  1  one-cycle pulse per bad frame
- selftest_ok  out  1  sticky: 0xAA received

Behaviour:
- Reset: async on rst_n low. All outputs 0, FIFO empty, FSM in IDLE, receiver bit count 0, synchronisers cleared to 1.
- Sync: kbdclk and kbddat each pass through a 2-flop synchroniser. A fall is synced kbdclk going 1->0; each fall samples synced kbddat.
- Frame format: 11 bits.
  - Start bit 0.
  - 8 data bits, LSB first.
  - Odd parity bit.
  - Stop bit 1.
- Frame errors: bad start, bad parity or bad stop drops the byte and pulses frame_err. The bit count returns to 0.
- Start-bit handling: a start bit of 1 is rejected immediately and the bit count stays at 0.
- Timeout: a counter runs while the bit count is nonzero. It reaches TIMEOUT_CYCLES with no fall -> bit count cleared, frame_err pulses.
- Receiver latency: a valid byte strobes internally 1 clk after the stop-bit fall.
- FSM states: IDLE, BRK, EXT, EXT_BRK.
  - IDLE: F0 -> BRK; E0 -> EXT; AA -> set selftest_ok, stay; mapped code -> push make event; other -> ignore.
  - BRK: mapped code -> push release event if REPORT_RELEASE; any byte -> IDLE.
  - EXT: F0 -> EXT_BRK; any other byte -> IDLE, no event (extended keys are ignored).
  - EXT_BRK: any byte -> IDLE, no event.
- Letter map (scancode -> index):
  - 1C=1, 32=2, 21=3, 23=4, 24=5, 2B=6
  - 34=7, 33=8, 3B=9, 4B=10, 31=11, 44=12
  - 4D=13, 15=14, 2D=15, 1B=16, 3C=17, 35=18
  - All other codes are unmapped and produce no event.
- Event latency: push occurs 1 clk after the byte strobe. With the FIFO empty, evt_valid rises 3 clk after the stop-bit fall. There is no fall-through.
- FIFO handshake: the head is popped on evt_valid & evt_ready. evt_letter/evt_release are stable while evt_valid=1 and evt_ready=0.
- Full FIFO:
  - A push is accepted only if not full, or if a pop happens in the same cycle.
  - Otherwise the event is dropped, overflow is set and the count is unchanged.
- Empty FIFO: a pop with evt_valid=0 has no effect. Simultaneous push into an empty FIFO with evt_ready=1 -> entry stored, visible next cycle.
- Pointers wrap modulo FIFO_DEPTH. fifo_count is exact, 0..FIFO_DEPTH.
- Reset mid-frame or mid-prefix: everything is discarded and no event is produced.

Test Plan:
- Frame 1C: evt_valid=1, letter=1, release=0 three clk after the stop fall. Pulse evt_ready -> count 0.
- Sequence F0,1C with REPORT_RELEASE=1: event letter=1, release=1. With REPORT_RELEASE=0: no event, FSM back in IDLE.
- Sequence E0,1C then E0,F0,1C: no events. A following 32 -> letter=2, proving a clean return to IDLE.
- 1C with the parity bit flipped: frame_err pulses for 1 cycle, no event. Next good 35 -> letter=18.
- Send 5 bits then idle TIMEOUT_CYCLES: frame_err pulses. Next full frame 2D -> letter=15.
- FIFO_DEPTH=4, evt_ready=0, 5 make codes:
  - count=4, overflow=1, head is the first code.
  - Drain with evt_ready=1 -> 4 events in order, evt_valid drops.
  - Then receive AA -> selftest_ok=1, no event.

Source files
------------

// File: rtl/ps2_key_event_fifo_if.sv
// Key event stream handshake between the PS/2 event FIFO
// and its consumer.
interface ps2_key_event_fifo_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [4:0] evt_letter;
  logic       evt_release;

  modport master (
    output evt_valid,
    output evt_letter,
    output evt_release,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_letter,
    input  evt_release,
    output evt_ready
  );
endinterface

// File: rtl/ps2_key_event_fifo.sv
// PS/2 receiver, make/break prefix FSM and letter event FIFO
// with a valid/ready head.
module ps2_key_event_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int REPORT_RELEASE = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kbdclk,
  input  logic kbddat,
  ps2_key_event_fifo_if.master evt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic overflow,
  output logic frame_err,
  output logic selftest_ok
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE, BRK, EXT, EXT_BRK
  } state_t;

  logic [1:0] ck_sync;
  logic [1:0] dt_sync;
  logic       ck_prev;
  logic       fall;
  logic       bit_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_sync <= 2'b11;
      dt_sync <= 2'b11;
      ck_prev <= 1'b1;
    end else begin
      ck_sync <= {ck_sync[0], kbdclk};
      dt_sync <= {dt_sync[0], kbddat};
      ck_prev <= ck_sync[1];
    end
  end

  assign fall   = ck_prev & ~ck_sync[1];
  assign bit_in = dt_sync[1];

  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tmo;
  logic          byte_stb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      tmo       <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        tmo <= '0;
        if (bit_cnt == 4'd0) begin
          if (!bit_in) bit_cnt <= 4'd1;
          else frame_err <= 1'b1;
        end else if (bit_cnt <= 4'd8) begin
          shreg   <= {bit_in, shreg[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          par     <= bit_in;
          bit_cnt <= 4'd10;
        end else begin
          bit_cnt <= '0;
          if (bit_in && (^shreg ^ par))
            byte_stb <= 1'b1;
          else
            frame_err <= 1'b1;
        end
      end else if (bit_cnt != 4'd0) begin
        // partial frame abandoned by the keyboard
        if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt   <= '0;
          tmo       <= '0;
          frame_err <= 1'b1;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end
    end
  end

  function automatic logic [4:0] letter_of(
    input logic [7:0] code
  );
    case (code)
      8'h1C:   letter_of = 5'd1;
      8'h32:   letter_of = 5'd2;
      8'h21:   letter_of = 5'd3;
      8'h23:   letter_of = 5'd4;
      8'h24:   letter_of = 5'd5;
      8'h2B:   letter_of = 5'd6;
      8'h34:   letter_of = 5'd7;
      8'h33:   letter_of = 5'd8;
      8'h3B:   letter_of = 5'd9;
      8'h4B:   letter_of = 5'd10;
      8'h31:   letter_of = 5'd11;
      8'h44:   letter_of = 5'd12;
      8'h4D:   letter_of = 5'd13;
      8'h15:   letter_of = 5'd14;
      8'h2D:   letter_of = 5'd15;
      8'h1B:   letter_of = 5'd16;
      8'h3C:   letter_of = 5'd17;
      8'h35:   letter_of = 5'd18;
      default: letter_of = 5'd0;
    endcase
  endfunction

  state_t     state;
  logic       push;
  logic [4:0] push_letter;
  logic       push_rel;
  logic [4:0] code_letter;

  assign code_letter = letter_of(shreg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      push        <= 1'b0;
      push_letter <= '0;
      push_rel    <= 1'b0;
      selftest_ok <= 1'b0;
    end else begin
      push <= 1'b0;
      if (byte_stb) begin
        unique case (state)
          IDLE: begin
            if (shreg == 8'hF0) begin
              state <= BRK;
            end else if (shreg == 8'hE0) begin
              state <= EXT;
            end else if (shreg == 8'hAA) begin
              selftest_ok <= 1'b1;
            end else if (code_letter != 5'd0) begin
              push        <= 1'b1;
              push_letter <= code_letter;
              push_rel    <= 1'b0;
            end
          end
          BRK: begin
            if (code_letter != 5'd0 &&
                REPORT_RELEASE != 0) begin
              push        <= 1'b1;
              push_letter <= code_letter;
              push_rel    <= 1'b1;
            end
            state <= IDLE;
          end
          EXT: begin
            if (shreg == 8'hF0) state <= EXT_BRK;
            else state <= IDLE;
          end
          EXT_BRK: state <= IDLE;
        endcase
      end
    end
  end

  logic [5:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic          full;
  logic          do_push;

  assign pop     = evt.evt_valid & evt.evt_ready;
  assign full    = fifo_count == CW'(FIFO_DEPTH);
  assign do_push = push & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {push_rel, push_letter};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) overflow <= 1'b1;
      unique case ({do_push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign evt.evt_valid = fifo_count != '0;
  assign {evt.evt_release, evt.evt_letter} =
    mem[rd_ptr];
endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Directed plus randomized bench for ps2_key_event_fifo:
// a depth-4 release-reporting unit and a depth-8 make-only unit.
module tb_ps2_key_event_fifo;
  localparam int H   = 8;
  localparam int TMO = 100;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic kbdclk = 1'b1;
  logic kbddat = 1'b1;

  always #5 clk = ~clk;

  ps2_key_event_fifo_if e4 ();
  ps2_key_event_fifo_if e8 ();

  logic [2:0] cnt4;
  logic [3:0] cnt8;
  logic ov4, ov8, fe4, fe8, st4, st8;

  ps2_key_event_fifo #(
    .FIFO_DEPTH(4), .REPORT_RELEASE(1),
    .TIMEOUT_CYCLES(TMO)
  ) u4 (
    .clk(clk), .rst_n(rst_n),
    .kbdclk(kbdclk), .kbddat(kbddat),
    .evt(e4), .fifo_count(cnt4),
    .overflow(ov4), .frame_err(fe4),
    .selftest_ok(st4)
  );

  ps2_key_event_fifo #(
    .FIFO_DEPTH(8), .REPORT_RELEASE(0),
    .TIMEOUT_CYCLES(TMO)
  ) u8 (
    .clk(clk), .rst_n(rst_n),
    .kbdclk(kbdclk), .kbddat(kbddat),
    .evt(e8), .fifo_count(cnt8),
    .overflow(ov8), .frame_err(fe8),
    .selftest_ok(st8)
  );

  int total = 0;
  int bad   = 0;
  int fe4_n = 0;
  int fe8_n = 0;

  always @(posedge clk) begin
    if (fe4 === 1'b1) fe4_n++;
    if (fe8 === 1'b1) fe8_n++;
  end

  logic [7:0] codes [18] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
    8'h34, 8'h33, 8'h3B, 8'h4B, 8'h31, 8'h44,
    8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h3C, 8'h35
  };
  logic [4:0] lmap [256];
  logic [5:0] q4 [$];
  logic [5:0] q8 [$];
  bit brk, ext, m_ov4, m_ov8, m_st;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic push4(input logic [5:0] v);
    if (q4.size() < 4) q4.push_back(v);
    else m_ov4 = 1'b1;
  endtask

  task automatic push8(input logic [5:0] v);
    if (q8.size() < 8) q8.push_back(v);
    else m_ov8 = 1'b1;
  endtask

  // prefix tracked as two flags: break seen, extended seen
  task automatic model_byte(input logic [7:0] b);
    logic [4:0] l;
    l = lmap[b];
    if (!brk && !ext) begin
      if (b == 8'hF0) brk = 1'b1;
      else if (b == 8'hE0) ext = 1'b1;
      else begin
        if (b == 8'hAA) m_st = 1'b1;
        if (l != 0) begin
          push4({1'b0, l});
          push8({1'b0, l});
        end
      end
    end else if (ext && !brk) begin
      if (b == 8'hF0) brk = 1'b1;
      else ext = 1'b0;
    end else begin
      if (!ext && l != 0) push4({1'b1, l});
      brk = 1'b0;
      ext = 1'b0;
    end
  endtask

  task automatic model_reset();
    q4.delete();
    q8.delete();
    brk = 0; ext = 0;
    m_ov4 = 0; m_ov8 = 0; m_st = 0;
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input bit bad_par,
                            input int nbits,
                            input bit lat);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      kbddat = f[i];
      repeat (H) @(negedge clk);
      kbdclk = 1'b0;
      if (lat && i == 10) begin
        repeat (4) @(posedge clk);
        #1 chk("lat_lo", e4.evt_valid, 0);
        @(posedge clk);
        #1 chk("lat_hi", e4.evt_valid, 1);
        repeat (H - 4) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      kbdclk = 1'b1;
    end
    @(negedge clk);
    kbddat = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_cnt4"}, cnt4, q4.size());
    chk({tag, "_cnt8"}, cnt8, q8.size());
    chk({tag, "_v4"}, e4.evt_valid, q4.size() != 0);
    chk({tag, "_v8"}, e8.evt_valid, q8.size() != 0);
    chk({tag, "_ov4"}, ov4, m_ov4);
    chk({tag, "_ov8"}, ov8, m_ov8);
    chk({tag, "_st4"}, st4, m_st);
    chk({tag, "_st8"}, st8, m_st);
    if (q4.size() != 0)
      chk({tag, "_head4"},
          {e4.evt_release, e4.evt_letter}, q4[0]);
    if (q8.size() != 0)
      chk({tag, "_head8"},
          {e8.evt_release, e8.evt_letter}, q8[0]);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0);
    model_byte(b);
    repeat (10) @(negedge clk);
    check_all($sformatf("byte%02h", b));
  endtask

  task automatic pop4();
    logic [5:0] v;
    if (q4.size() == 0) return;
    v = q4.pop_front();
    chk("pop4_v", e4.evt_valid, 1);
    chk("pop4_d", {e4.evt_release, e4.evt_letter}, v);
    e4.evt_ready = 1'b1;
    @(negedge clk);
    e4.evt_ready = 1'b0;
  endtask

  task automatic pop8();
    logic [5:0] v;
    if (q8.size() == 0) return;
    v = q8.pop_front();
    chk("pop8_v", e8.evt_valid, 1);
    chk("pop8_d", {e8.evt_release, e8.evt_letter}, v);
    e8.evt_ready = 1'b1;
    @(negedge clk);
    e8.evt_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (q4.size() != 0) pop4();
    while (q8.size() != 0) pop8();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int f4, f8, r;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) lmap[i] = 5'd0;
    for (int i = 0; i < 18; i++)
      lmap[codes[i]] = 5'(i + 1);
    model_reset();
    e4.evt_ready = 1'b0;
    e8.evt_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cnt4", cnt4, 0);
    chk("rst_cnt8", cnt8, 0);
    chk("rst_v4", e4.evt_valid, 0);
    chk("rst_head4", {e4.evt_release, e4.evt_letter}, 0);
    chk("rst_ov4", ov4, 0);
    chk("rst_fe4", fe4, 0);
    chk("rst_st4", st4, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send_frame(8'h1C, 1'b0, 11, 1'b1);
    model_byte(8'h1C);
    repeat (10) @(negedge clk);
    check_all("make1c");
    drain("make1c_drain");

    send(8'hF0);
    send(8'h1C);
    drain("brk1c");

    send(8'hE0);
    send(8'h1C);
    send(8'hE0);
    send(8'hF0);
    send(8'h1C);
    send(8'h32);
    drain("ext");

    f4 = fe4_n;
    f8 = fe8_n;
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    repeat (10) @(negedge clk);
    chk("par_fe4", fe4_n, f4 + 1);
    chk("par_fe8", fe8_n, f8 + 1);
    check_all("par");
    send(8'h35);
    drain("after_par");

    f4 = fe4_n;
    send_frame(8'h2D, 1'b0, 5, 1'b0);
    repeat (TMO + 20) @(negedge clk);
    chk("tmo_fe4", fe4_n, f4 + 1);
    check_all("tmo");
    send(8'h2D);
    drain("after_tmo");

    for (int i = 0; i < 5; i++) send(codes[i]);
    chk("full_cnt4", cnt4, 4);
    chk("full_ov4", ov4, 1);
    chk("full_head4", e4.evt_letter, 1);
    drain("full_drain");
    send(8'hAA);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55) b = codes[$urandom_range(0, 17)];
      else if (r < 70) b = 8'hF0;
      else if (r < 80) b = 8'hE0;
      else if (r < 84) b = 8'hAA;
      else b = 8'($urandom_range(0, 255));
      send(b);
      if ($urandom_range(0, 9) < 4) begin
        r = $urandom_range(0, 2);
        for (int k = 0; k < r; k++) begin
          pop4();
          pop8();
        end
        @(negedge clk);
        check_all("rnd_pop");
      end
    end
    drain("rnd_drain");

    send(8'hF0);
    send_frame(8'h32, 1'b0, 4, 1'b0);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all("midrst");
    send(8'h1C);
    drain("midrst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
